// File: rtl/core_pio_pkg.sv
// Shared constants for the core PIO peripheral: Avalon register map and
// edge-capture mode encodings.
package core_pio_pkg;

    // Register map (word addresses on the 3-bit Avalon address bus)
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge-capture modes selected by the EDGE_TYPE parameter
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage : core_pio_pkg

// File: rtl/core_pio_sync.sv
// Two-flop synchroniser for the asynchronous PIO pin inputs. Each bit is
// synchronised independently; no multi-bit coherence is implied.
module core_pio_sync #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the pins through two flops to resolve metastability
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true two-stage pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : core_pio_sync

// File: rtl/core_pio_ext.sv
// WIDTH-bit general-purpose I/O port on the Avalon-MM bus: per-bit direction,
// atomic set/clear of the output register, synchronised inputs, sticky edge
// capture and a maskable, registered level interrupt.
module core_pio_ext
    import core_pio_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter int               EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] rd_bits;
    logic             unused_wdata;

    assign wr_en   = chipselect & ~write_n;
    assign wdata   = writedata[WIDTH-1:0];
    assign pio_out = data_out;
    assign pio_oe  = dir_reg;

    // Bits of writedata above WIDTH carry no meaning for this port
    assign unused_wdata = ^writedata;

    core_pio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pio_in),
        .q       (in_sync)
    );

    // Delay the synchronised inputs one cycle for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev <= '0;
        end else begin
            in_prev <= in_sync;
        end
    end

    // Select the edge kind this instance captures
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        edge_bits = '0;
        case (EDGE_TYPE)
            EDGE_FALL: edge_bits = ~in_sync & in_prev;
            EDGE_ANY:  edge_bits = in_sync ^ in_prev;
            default:   edge_bits = in_sync & ~in_prev;
        endcase
    end

    // Write-1-to-clear mask for the edge-capture register
    always_comb begin
        clr_bits = '0;
        if (wr_en && address == ADDR_EDGE) begin
            clr_bits = wdata;
        end
    end

    // Software-visible control registers; reserved addresses ignore writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir_reg  <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out <= wdata;
                ADDR_DIR:     dir_reg  <= wdata;
                ADDR_IRQMASK: irq_mask <= wdata;
                ADDR_OUTSET:  data_out <= data_out | wdata;
                ADDR_OUTCLR:  data_out <= data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    // Sticky edge capture; a fresh edge on a bit wins over its clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr_bits) | edge_bits;
        end
    end

    // Registered level interrupt from any unmasked captured edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_cap & irq_mask);
        end
    end

    // Combinational read mux; outset/outclear and reserved addresses read 0
    always_comb begin
        rd_bits = '0;
        case (address)
            ADDR_DATA:    rd_bits = (data_out & dir_reg) | (in_sync & ~dir_reg);
            ADDR_DIR:     rd_bits = dir_reg;
            ADDR_IRQMASK: rd_bits = irq_mask;
            ADDR_EDGE:    rd_bits = edge_cap;
            default:      rd_bits = '0;
        endcase
    end

    // Zero-extend the port-width read value onto the 32-bit bus
    always_comb begin
        readdata              = '0;
        readdata[WIDTH-1:0]   = rd_bits;
    end

endmodule : core_pio_ext

// File: tb/tb_core_pio_ext.sv
// Self-checking bench for core_pio_ext: two instances (rising and any-edge
// capture) share the bus and pins; a history-based model predicts results.
module tb_core_pio_ext;

    localparam int W = 10;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] pio_in;

    logic [31:0]  rd_r, rd_a;
    logic [W-1:0] out_r, out_a, oe_r, oe_a;
    logic         irq_r, irq_a;

    int n_total = 0;
    int n_pass  = 0;

    core_pio_ext #(
        .WIDTH(W), .DIR_RESET(10'h3FF), .OUT_RESET(10'h155), .EDGE_TYPE(0)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r),
        .pio_in(pio_in), .pio_out(out_r), .pio_oe(oe_r), .irq(irq_r)
    );

    core_pio_ext #(
        .WIDTH(W), .DIR_RESET(10'h3FF), .OUT_RESET(10'h155), .EDGE_TYPE(2)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .pio_in(pio_in), .pio_out(out_a), .pio_oe(oe_a), .irq(irq_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // seen[i] is the pin value sampled at the i-th most recent clock edge.
    // The design sees a pin one edge late (in_sync) and compares it with the
    // value one edge older still; a capture lands on the edge after that.
    logic [W-1:0] m_out, m_dir, m_mask, m_cap_r, m_cap_a;
    logic [W-1:0] seen0, seen1, seen2;
    logic         m_irq_r, m_irq_a;
    logic         m_wr;
    logic [W-1:0] m_clr;

    assign m_wr  = chipselect & ~write_n;
    assign m_clr = (m_wr && address == 3'd3) ? writedata[W-1:0] : '0;

    function automatic logic [W-1:0] edge_of(input int kind, input logic [W-1:0] cur,
                                             input logic [W-1:0] prev);
        if (kind == 2) return cur ^ prev;
        if (kind == 1) return ~cur & prev;
        return cur & ~prev;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out <= 10'h155; m_dir <= 10'h3FF; m_mask <= '0;
            m_cap_r <= '0; m_cap_a <= '0; m_irq_r <= 1'b0; m_irq_a <= 1'b0;
            seen0 <= '0; seen1 <= '0; seen2 <= '0;
        end else begin
            m_cap_r <= (m_cap_r & ~m_clr) | edge_of(0, seen1, seen2);
            m_cap_a <= (m_cap_a & ~m_clr) | edge_of(2, seen1, seen2);
            m_irq_r <= |(m_cap_r & m_mask);
            m_irq_a <= |(m_cap_a & m_mask);
            seen0 <= pio_in; seen1 <= seen0; seen2 <= seen1;
            if (m_wr) begin
                case (address)
                    3'd0: m_out  <= writedata[W-1:0];
                    3'd1: m_dir  <= writedata[W-1:0];
                    3'd2: m_mask <= writedata[W-1:0];
                    3'd4: m_out  <= m_out | writedata[W-1:0];
                    3'd5: m_out  <= m_out & ~writedata[W-1:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a, input bit any);
        logic [W-1:0] v;
        case (a)
            3'd0: v = (m_out & m_dir) | (seen1 & ~m_dir);
            3'd1: v = m_dir;
            3'd2: v = m_mask;
            3'd3: v = any ? m_cap_a : m_cap_r;
            default: v = '0;
        endcase
        return {22'b0, v};
    endfunction

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] vr, output logic [31:0] va);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        vr = rd_r; va = rd_a;
        chipselect = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] vr, va;
        reset_n = 1'b0; pio_in = '0; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        n_total++; if (oe_r !== 10'h3FF) $display("FAIL reset_oe: got %h want 3ff", oe_r); else n_pass++;
        n_total++; if (out_r !== 10'h155) $display("FAIL reset_out: got %h want 155", out_r); else n_pass++;
        n_total++; if (irq_r !== 1'b0 || irq_a !== 1'b0) $display("FAIL reset_irq: got %b%b want 00", irq_r, irq_a); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(3'd1, vr, va);
        n_total++; if (vr !== 32'h3FF) $display("FAIL reset_dir_read: got %h want 000003ff", vr); else n_pass++;
        bus_read(3'd0, vr, va);
        n_total++; if (vr !== 32'h155) $display("FAIL reset_data_read: got %h want 00000155", vr); else n_pass++;
    endtask

    task automatic test_set_clear;
        logic [31:0] vr, va;
        bus_write(3'd0, 32'h0F0);
        n_total++; if (out_r !== 10'h0F0) $display("FAIL data_write: got %h want 0f0", out_r); else n_pass++;
        bus_write(3'd4, 32'h003);
        n_total++; if (out_r !== 10'h0F3) $display("FAIL outset: got %h want 0f3", out_r); else n_pass++;
        bus_write(3'd5, 32'h010);
        n_total++; if (out_r !== 10'h0E3) $display("FAIL outclear: got %h want 0e3", out_r); else n_pass++;
        bus_read(3'd0, vr, va);
        n_total++; if (vr !== 32'h0E3) $display("FAIL data_read_out: got %h want 000000e3", vr); else n_pass++;
        bus_read(3'd4, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL outset_read: got %h want 0", vr); else n_pass++;
        bus_read(3'd5, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL outclear_read: got %h want 0", vr); else n_pass++;
    endtask

    task automatic test_edge_irq;
        logic [31:0] vr, va;
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h004);
        bus_write(3'd3, 32'h3FF);
        pio_in[2] = 1'b1;                 // settles before edge k
        @(negedge clk);                   // after k
        bus_read(3'd0, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL sync_k: got %h want 0", vr); else n_pass++;
        @(negedge clk);                   // after k+1
        bus_read(3'd0, vr, va);
        n_total++; if (vr !== 32'h004) $display("FAIL sync_k1: got %h want 004", vr); else n_pass++;
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL cap_k1: got %h want 0", vr); else n_pass++;
        @(negedge clk);                   // after k+2
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h004) $display("FAIL cap_k2: got %h want 004", vr); else n_pass++;
        n_total++; if (irq_r !== 1'b0) $display("FAIL irq_k2: got %b want 0", irq_r); else n_pass++;
        @(negedge clk);                   // after k+3
        n_total++; if (irq_r !== 1'b1) $display("FAIL irq_k3: got %b want 1", irq_r); else n_pass++;
        address = 3'd3; writedata = 32'h004; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);                   // after clear edge j
        chipselect = 1'b0; write_n = 1'b1;
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL cap_cleared: got %h want 0", vr); else n_pass++;
        @(negedge clk);                   // after j+1
        n_total++; if (irq_r !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq_r); else n_pass++;
    endtask

    task automatic test_same_cycle;
        logic [31:0] vr, va;
        pio_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'h3FF);
        pio_in[2] = 1'b1;                 // edge k next
        @(negedge clk);
        @(negedge clk);                   // after k+1: clear lands on k+2
        address = 3'd3; writedata = 32'h004; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h004) $display("FAIL set_beats_clear: got %h want 004", vr); else n_pass++;
        bus_write(3'd3, 32'h004);
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL later_clear: got %h want 0", vr); else n_pass++;
    endtask

    task automatic test_any_edge;
        logic [31:0] vr, va;
        bus_write(3'd2, 32'h0);
        bus_write(3'd3, 32'h3FF);
        pio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        pio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(3'd3, vr, va);
        n_total++; if (va !== 32'h001) $display("FAIL any_cap: got %h want 001", va); else n_pass++;
        n_total++; if (irq_a !== 1'b0) $display("FAIL any_irq_masked: got %b want 0", irq_a); else n_pass++;
        bus_write(3'd2, 32'h001);         // mask set at edge m
        n_total++; if (irq_a !== 1'b0) $display("FAIL any_irq_m: got %b want 0", irq_a); else n_pass++;
        @(negedge clk);                   // after m+1
        n_total++; if (irq_a !== 1'b1) $display("FAIL any_irq_m1: got %b want 1", irq_a); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] vr, va;
        logic [2:0]  a;
        int          errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_total++;
            if (out_r !== m_out || out_a !== m_out || oe_r !== m_dir || oe_a !== m_dir ||
                irq_r !== m_irq_r || irq_a !== m_irq_a) begin
                $display("FAIL rand_outputs[%0d]: got out %h/%h oe %h/%h irq %b/%b want out %h oe %h irq %b/%b",
                         i, out_r, out_a, oe_r, oe_a, irq_r, irq_a, m_out, m_dir, m_irq_r, m_irq_a);
            end else n_pass++;
            a = 3'($urandom_range(0, 7));
            bus_read(a, vr, va);
            n_total++;
            if (vr !== model_read(a, 1'b0) || va !== model_read(a, 1'b1)) begin
                $display("FAIL rand_read[%0d] addr %0d: got %h/%h want %h/%h",
                         i, a, vr, va, model_read(a, 1'b0), model_read(a, 1'b1));
            end else n_pass++;
            address    = a;
            writedata  = $urandom;
            chipselect = 1'b1;
            write_n    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) pio_in = W'($urandom);
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset_midstream;
        logic [31:0] vr, va;
        pio_in = '0;
        bus_write(3'd2, 32'h3FF);
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'h3FF);
        pio_in = 10'h3FF;
        repeat (4) @(negedge clk);
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h3FF) $display("FAIL pre_reset_cap: got %h want 3ff", vr); else n_pass++;
        n_total++; if (irq_r !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq_r); else n_pass++;
        address = 3'd0; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (out_r !== 10'h155 || oe_r !== 10'h3FF) $display("FAIL async_reset_out: got %h/%h want 155/3ff", out_r, oe_r); else n_pass++;
        n_total++; if (irq_r !== 1'b0 || irq_a !== 1'b0) $display("FAIL async_reset_irq: got %b%b want 00", irq_r, irq_a); else n_pass++;
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h0 || va !== 32'h0) $display("FAIL async_reset_cap: got %h/%h want 0", vr, va); else n_pass++;
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);                   // a write-active edge passes under reset
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b1;
        n_total++; if (out_r !== 10'h155) $display("FAIL write_discarded: got %h want 155", out_r); else n_pass++;
        bus_read(3'd6, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL reserved_read: got %h want 0", vr); else n_pass++;
        @(negedge clk);                   // after e1
        @(negedge clk);                   // after e2
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h0) $display("FAIL post_reset_cap_e2: got %h want 0", vr); else n_pass++;
        @(negedge clk);                   // after e3
        bus_read(3'd3, vr, va);
        n_total++; if (vr !== 32'h3FF) $display("FAIL post_reset_cap_e3: got %h want 3ff", vr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_edge_irq();
        test_same_cycle();
        test_any_edge();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_core_pio_ext

// File: doc/core_pio_ext.md
# core_pio_ext

Parametrised successor to the core's single-register output PIO: a WIDTH-bit general-purpose I/O port on the Avalon-MM system bus with per-bit direction, atomic bit set/clear, synchronised inputs, edge capture and a maskable level interrupt. It sits beside the other core peripherals as an Avalon slave and drives or samples board-level pins through separate in/out/output-enable vectors; tri-state buffers live in the top level.

## Interface
Parameters:
- WIDTH, 10, port width, 1..32
- DIR_RESET, 0, reset value of the direction register (1 = output)
- OUT_RESET, 0, reset value of the output data register
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- readdata  out  32  read data, combinational; bits above WIDTH read 0
- pio_in  in  WIDTH  asynchronous pin inputs
- pio_out  out  WIDTH  output data register
- pio_oe  out  WIDTH  output enables (= direction register)
- irq  out  1  level interrupt, registered

## Operation
- Write = chipselect & ~write_n. Reads have no side effects; zero wait states.
- Register map: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear; 6-7 reserved (read 0, writes ignored).
- data: write loads data_out. Read returns (data_out & dir) | (in_sync & ~dir).
- direction: R/W, 1 = output; drives pio_oe.
- irqmask: R/W, reset 0.
- edgecapture: read returns sticky bits; write-1-to-clear per bit.
- outset: write ORs writedata into data_out; outclear: write ANDs ~writedata. Both read 0.
- Input path: pio_in → two-flop synchroniser → in_sync → in_prev. Edge per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = XOR. Edges detected on output-direction bits are still captured.
- Priority on same cycle: new edge set beats write-1-to-clear for that bit.
- irq next cycle = |(edgecapture & irqmask), registered.
- Reset: data_out=OUT_RESET, dir=DIR_RESET, irqmask=0, edgecapture=0, sync/prev flops=0, irq=0. Reset mid-write discards the write.

## Timing
- Register writes take effect at the clk edge of the write cycle; pio_out/pio_oe change that edge.
- Pin change settled before edge k: in_sync updates at edge k+1 (visible in data read after k+1); edgecapture bit set at edge k+2; irq asserts at edge k+3 if masked in.
- Clearing edgecapture at edge j deasserts irq at edge j+1 (unless another capture occurs).
- Changing irqmask affects irq one cycle later.
- Pulses narrower than one clk period may be missed; no requirement to catch them.
- After reset release, in_prev=0 so a pin held high produces a rising capture at the third edge; software clears it before unmasking.

## Structure
- Package core_pio_pkg: address constants (ADDR_DATA..ADDR_OUTCLR), edge-type constants (EDGE_RISE/FALL/ANY).
- Sub-module core_pio_sync: WIDTH-parametrised two-flop synchroniser with async active-low reset; top module holds registers, edge logic, read mux.

## Test plan
- Reset, WIDTH=10, DIR_RESET=0x3FF, OUT_RESET=0x155 → pio_oe=0x3FF, pio_out=0x155, irq=0, read addr1=0x3FF.
- Write data=0x0F0, outset 0x003, outclear 0x010 → pio_out sequence 0x0F0, 0x0F3, 0x0E3; read addr0 with dir=0x3FF returns 0x0E3.
- dir=0, EDGE_TYPE=0, irqmask=0x004, pio_in bit2 0→1 → edgecapture=0x004 at k+2, irq=1 at k+3; write 0x004 to addr3 → irq=0 next cycle.
- Same-cycle new edge on bit2 and write-1-to-clear bit2 → edgecapture bit2 stays 1.
- EDGE_TYPE=2, toggle bit0 twice, irqmask=0 → edgecapture=0x001, irq stays 0; set irqmask=0x001 → irq=1 one cycle later.
- Assert reset_n low mid-stream with edgecapture=0x3FF, irq=1 → all outputs return to reset values asynchronously; read addr6 returns 0.
